snoop_mesi_ctrl: RTL and testbench
==================================

Name: snoop_mesi_ctrl

Overview:
Parametrised successor to the two-cache MSI snooping state machines. Holds per-line MESI state for N_CACHES private caches of LINES lines each. Serialises processor requests through a round-robin bus arbiter and broadcasts one bus transaction at a time. All other caches snoop and update in that same cycle. Sits between the processor request sources (bench or cores) and the shared bus model.

Parameters:
N_CACHES, 2, number of snooping caches (2..8)
LINES, 4, lines tracked per cache (power of 2)
ADDR_W, $clog2(LINES), derived line-index width; not overridden

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
req_valid  in  N_CACHES  per-cache request pending; held until req_ready
req_write  in  N_CACHES  1=write, 0=read
req_addr  in  N_CACHES*ADDR_W  per-cache line index, cache i at [i*ADDR_W +: ADDR_W]
req_ready  out  N_CACHES  one-hot one-cycle accept pulse
done  out  N_CACHES  one-hot one-cycle completion pulse
bus_valid  out  1  bus transaction this cycle
bus_op  out  2  0 none, 1 BusRd, 2 BusRdX, 3 BusUpgr
bus_src  out  $clog2(N_CACHES)  requesting cache
bus_addr  out  ADDR_W  line index on bus
bus_flush  out  1  a snooper held M and writes back this cycle
dbg_cache  in  $clog2(N_CACHES)  debug query cache
dbg_addr  in  ADDR_W  debug query line
dbg_state  out  2  combinational state[dbg_cache][dbg_addr]
stat_bus_cnt  out  16  bus transaction count (see Optional Feature)
stat_flush_cnt  out  16  flush count (see Optional Feature)

Behaviour:
- Encoding: I=0, S=1, E=2, M=3.
- Reset (async assert, sync release): all lines I; FSM IDLE; rr pointer 0; all outputs 0.
- FSM states: IDLE, LOOKUP, BUS, COMPLETE.
- IDLE: if any req_valid, grant the first requester at or after rr pointer (wrapping). Pulse req_ready[g]. Latch g, write and addr. Go to LOOKUP.
- LOOKUP: classify the requester's line.
  - Hit (read with S/E/M, or write with E/M): go to COMPLETE, no bus.
  - Otherwise: go to BUS.
- BUS: exactly one cycle with bus_valid=1.
  - Read miss (I): BusRd. Snoopers go M→S (bus_flush=1), E→S, S→S. Requester gets S if any snooper held non-I, else E.
  - Write miss (I): BusRdX. Snoopers go to I; M also asserts bus_flush. Requester gets M.
  - Write on S: BusUpgr. Snoopers go to I, no flush. Requester gets M.
- COMPLETE: requester line updated (hit write E→M; hit read unchanged). Pulse done[g]. rr pointer = g+1 mod N_CACHES. Go to IDLE.
- Latency: grant→done is 2 cycles on a hit, 3 cycles on a miss or upgrade. Back-to-back grants are 3 or 4 cycles apart.
- Requests arriving during a transaction wait. req_valid dropped before req_ready is simply not granted.
- Invariant: per line, at most one cache in M or E. If any cache is in M or E, every other cache is I.
- Reset asserted mid-transaction: transaction abandoned, no done pulse, states cleared.
- dbg_* is a purely combinational read; never affects state.

Optional Feature:
SNOOP_STATS_EN
- Defined: stat_bus_cnt increments on every bus_valid cycle. stat_flush_cnt increments on every bus_flush cycle. Both are 16-bit, saturate at 16'hFFFF, and are cleared by reset.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Package snoop_pkg holds:
  - mesi_t (2-bit enum I/S/E/M)
  - bus_op_t (NONE/BUSRD/BUSRDX/BUSUPGR)
  - ctrl_state_t (IDLE/LOOKUP/BUS/COMPLETE)
  - function next_snoop_state(mesi_t, bus_op_t) returning new state plus flush flag
- One sub-module: snoop_rr_arbiter. Parametrised N, inputs req vector and pointer, outputs one-hot grant and index.

Test Plan:
- N_CACHES=2. Reset, cache0 reads line 1 → BusRd, bus_flush=0, cache0 line1=E, done[0] 3 cycles after req_ready[0].
- Then cache0 writes line 1 → no bus_valid, line1 E→M, done 2 cycles after grant.
- Then cache1 reads line 1 → BusRd with bus_flush=1; cache0 line1=S, cache1 line1=S.
- Then cache1 writes line 1 → BusUpgr; cache0=I, cache1=M, bus_flush=0.
- Both req_valid high continuously with rr=0 → grants alternate 0,1,0,1; never two req_ready bits in one cycle.
- Reset_n low during BUS cycle of a BusRdX → no done pulse, all dbg_state reads 0. With SNOOP_STATS_EN, counters read 0 after reset and 1/0 after one miss without flush.

Source files
------------

// File: rtl/snoop_pkg.sv
// ---------------------------------------------------------------------------
// snoop_pkg
// Shared types and helpers for the MESI snooping controller:
//   mesi_t           per-line coherence state (I=0, S=1, E=2, M=3)
//   bus_op_t         bus transaction kind (NONE/BUSRD/BUSRDX/BUSUPGR)
//   ctrl_state_t     controller FSM states (IDLE/LOOKUP/BUS/COMPLETE)
//   snoop_res_t      snooper next state plus write-back (flush) flag
//   next_snoop_state how a non-requesting cache reacts to a bus operation
// ---------------------------------------------------------------------------
package snoop_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_BUSRD   = 2'd1,
    OP_BUSRDX  = 2'd2,
    OP_BUSUPGR = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOOKUP   = 2'd1,
    ST_BUS      = 2'd2,
    ST_COMPLETE = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    mesi_t state;
    logic  flush;
  } snoop_res_t;

  // A snooper holding the only dirty copy must write it back whenever
  // another cache reads or takes ownership of the line. An upgrade can only
  // be seen by caches holding S or I, so it never needs a flush.
  function automatic snoop_res_t next_snoop_state(input mesi_t cur, input bus_op_t op);
    snoop_res_t r;
    r.state = cur;
    r.flush = 1'b0;
    case (op)
      OP_BUSRD: begin
        if (cur != MESI_I) r.state = MESI_S;
        r.flush = (cur == MESI_M);
      end
      OP_BUSRDX: begin
        r.state = MESI_I;
        r.flush = (cur == MESI_M);
      end
      OP_BUSUPGR: begin
        r.state = MESI_I;
      end
      default: begin
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snoop_rr_arbiter.sv
// ---------------------------------------------------------------------------
// snoop_rr_arbiter
// Combinational round-robin arbiter: picks the first asserted request at or
// after the pointer, wrapping around.
// Ports:
//   req   [N-1:0]      request vector
//   ptr   [IDX_W-1:0]  highest-priority index this round
//   grant [N-1:0]      one-hot grant (all zero if no request)
//   idx   [IDX_W-1:0]  index of the granted request
//   any                at least one request is asserted
// ---------------------------------------------------------------------------
module snoop_rr_arbiter
  import snoop_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk the requests in rotated order starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/snoop_mesi_ctrl.sv
// ---------------------------------------------------------------------------
// snoop_mesi_ctrl
// MESI coherence controller for N_CACHES private caches of LINES lines each.
// Processor requests are serialised by a round-robin arbiter; one bus
// transaction is broadcast at a time and every other cache snoops it in the
// same cycle.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req_valid/write  per-cache request and direction (1 = write)
//   req_addr         per-cache line index, cache i at [i*ADDR_W +: ADDR_W]
//   req_ready        one-hot accept pulse
//   done             one-hot completion pulse
//   bus_valid/op/src/addr/flush  the broadcast bus transaction
//   dbg_cache/addr   combinational state query -> dbg_state
//   stat_bus_cnt/stat_flush_cnt  saturating activity counters
// Optional feature macro: SNOOP_STATS_EN (counters present only if defined;
// otherwise both stat ports are tied to zero).
// ---------------------------------------------------------------------------
module snoop_mesi_ctrl
  import snoop_pkg::*;
#(
  parameter  int N_CACHES = 2,
  parameter  int LINES    = 4,
  localparam int ADDR_W   = $clog2(LINES),
  localparam int SRC_W    = (N_CACHES > 1) ? $clog2(N_CACHES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CACHES-1:0]        req_valid,
  input  logic [N_CACHES-1:0]        req_write,
  input  logic [N_CACHES*ADDR_W-1:0] req_addr,
  output logic [N_CACHES-1:0]        req_ready,
  output logic [N_CACHES-1:0]        done,
  output logic                       bus_valid,
  output logic [1:0]                 bus_op,
  output logic [SRC_W-1:0]           bus_src,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic                       bus_flush,
  input  logic [SRC_W-1:0]           dbg_cache,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [1:0]                 dbg_state,
  output logic [15:0]                stat_bus_cnt,
  output logic [15:0]                stat_flush_cnt
);

  ctrl_state_t      state_q;
  mesi_t            line_st [N_CACHES][LINES];
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] lat_src;
  logic             lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic             lat_shared;
  bus_op_t          bus_op_q;

  logic [N_CACHES-1:0] arb_grant;
  logic [SRC_W-1:0]    arb_idx;
  logic                arb_any;

  mesi_t      req_st;
  bus_op_t    lk_op;
  bus_op_t    op_sel;
  logic       lk_flush;
  logic       lk_shared;
  snoop_res_t sr;
  mesi_t      snp_next [N_CACHES];

  snoop_rr_arbiter #(
    .N     (N_CACHES),
    .IDX_W (SRC_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Classify the latched request and work out what the snoopers would do.
  // During LOOKUP the candidate operation decides flush/shared; during BUS
  // the registered operation drives the snooper next states that get
  // committed at the end of that cycle.
  always_comb begin
    req_st = line_st[lat_src][lat_addr];
    lk_op  = OP_NONE;
    if (req_st == MESI_I)
      lk_op = lat_write ? OP_BUSRDX : OP_BUSRD;
    else if (lat_write && (req_st == MESI_S))
      lk_op = OP_BUSUPGR;
    op_sel    = (state_q == ST_BUS) ? bus_op_q : lk_op;
    lk_flush  = 1'b0;
    lk_shared = 1'b0;
    sr        = '0;
    for (int j = 0; j < N_CACHES; j++) begin
      sr                   = next_snoop_state(line_st[SRC_W'(j)][lat_addr], op_sel);
      snp_next[SRC_W'(j)]  = sr.state;
      if (SRC_W'(j) != lat_src) begin
        lk_flush  = lk_flush | sr.flush;
        lk_shared = lk_shared | (line_st[SRC_W'(j)][lat_addr] != MESI_I);
      end
    end
  end

  // Main controller: one request at a time through IDLE -> LOOKUP ->
  // (BUS) -> COMPLETE. All handshake and bus outputs are registered pulses
  // that default to zero every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr     <= '0;
      lat_src    <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_shared <= 1'b0;
      req_ready  <= '0;
      done       <= '0;
      bus_valid  <= 1'b0;
      bus_op_q   <= OP_NONE;
      bus_src    <= '0;
      bus_addr   <= '0;
      bus_flush  <= 1'b0;
      for (int i = 0; i < N_CACHES; i++)
        for (int l = 0; l < LINES; l++)
          line_st[SRC_W'(i)][ADDR_W'(l)] <= MESI_I;
    end else begin
      req_ready <= '0;
      done      <= '0;
      bus_valid <= 1'b0;
      bus_op_q  <= OP_NONE;
      bus_src   <= '0;
      bus_addr  <= '0;
      bus_flush <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            req_ready <= arb_grant;
            lat_src   <= arb_idx;
            lat_write <= req_write[arb_idx];
            lat_addr  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
            state_q   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lk_op == OP_NONE) begin
            state_q <= ST_COMPLETE;
          end else begin
            bus_valid  <= 1'b1;
            bus_op_q   <= lk_op;
            bus_src    <= lat_src;
            bus_addr   <= lat_addr;
            bus_flush  <= lk_flush;
            lat_shared <= lk_shared;
            state_q    <= ST_BUS;
          end
        end
        ST_BUS: begin
          for (int j = 0; j < N_CACHES; j++)
            if (SRC_W'(j) != lat_src)
              line_st[SRC_W'(j)][lat_addr] <= snp_next[SRC_W'(j)];
          // A read miss only gets exclusive ownership if nobody else has it.
          case (bus_op_q)
            OP_BUSRD:   line_st[lat_src][lat_addr] <= lat_shared ? MESI_S : MESI_E;
            OP_BUSRDX,
            OP_BUSUPGR: line_st[lat_src][lat_addr] <= MESI_M;
            default: begin
            end
          endcase
          state_q <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          // Write hits silently promote E to M; M stays M.
          if (lat_write)
            line_st[lat_src][lat_addr] <= MESI_M;
          done[lat_src] <= 1'b1;
          rr_ptr        <= (lat_src == SRC_W'(N_CACHES - 1)) ? '0 : lat_src + SRC_W'(1);
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_op    = bus_op_q;
  assign dbg_state = (int'(dbg_cache) < N_CACHES) ? line_st[dbg_cache][dbg_addr] : MESI_I;

`ifdef SNOOP_STATS_EN
  logic [15:0] bus_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating counters of bus transactions and write-backs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus_valid && (bus_cnt_q != 16'hFFFF))
        bus_cnt_q <= bus_cnt_q + 16'd1;
      if (bus_flush && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stat_bus_cnt   = bus_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`else
  assign stat_bus_cnt   = '0;
  assign stat_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_snoop_mesi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snoop_mesi_ctrl
// Self-checking bench for snoop_mesi_ctrl with two caches of four lines.
// A table of requests with expected bus behaviour and resulting line states
// is replayed; a scoreboard queue holds the expected transaction for each
// request and a monitor checks bus and completion pulses against it.
// Hand-written sequences cover arbitration fairness and reset mid-transfer.
// ---------------------------------------------------------------------------
module tb_snoop_mesi_ctrl;

  localparam int ST_I = 0;
  localparam int ST_S = 1;
  localparam int ST_E = 2;
  localparam int ST_M = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_write;
  logic [3:0] req_addr;
  logic [1:0] req_ready;
  logic [1:0] done;
  logic       bus_valid;
  logic [1:0] bus_op;
  logic       bus_src;
  logic [1:0] bus_addr;
  logic       bus_flush;
  logic       dbg_cache;
  logic [1:0] dbg_addr;
  logic [1:0] dbg_state;
  logic [15:0] stat_bus_cnt;
  logic [15:0] stat_flush_cnt;

  typedef struct {
    int cache;
    bit wr;
    int addr;
    int exp_op;
    bit exp_flush;
    int exp_req_st;
    int exp_oth_st;
    int exp_lat;
  } vec_t;

  typedef struct {
    int src;
    int addr;
    int op;
    bit flush;
    int lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];

  int checks;
  int errors;
  int cyc;
  int grant_cyc;
  bit bus_seen;
  bit mon_en;

  snoop_mesi_ctrl #(
    .N_CACHES (2),
    .LINES    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .done           (done),
    .bus_valid      (bus_valid),
    .bus_op         (bus_op),
    .bus_src        (bus_src),
    .bus_addr       (bus_addr),
    .bus_flush      (bus_flush),
    .dbg_cache      (dbg_cache),
    .dbg_addr       (dbg_addr),
    .dbg_state      (dbg_state),
    .stat_bus_cnt   (stat_bus_cnt),
    .stat_flush_cnt (stat_flush_cnt)
  );

  // Free-running clock and cycle counter used for latency measurement.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Monitor: checks accept pulses, bus transactions and completions against
  // the scoreboard front entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (req_ready != 2'b00) begin
        checkOutput("ready_onehot", int'($onehot(req_ready)), 1);
        grant_cyc = cyc;
        bus_seen  = 1'b0;
      end
      if (bus_valid) begin
        bus_seen = 1'b1;
        if (sb.size() == 0) begin
          checkOutput("bus_unexpected", 1, 0);
        end else begin
          checkOutput("bus_op", int'(bus_op), sb[0].op);
          checkOutput("bus_src", int'(bus_src), sb[0].src);
          checkOutput("bus_addr", int'(bus_addr), sb[0].addr);
          checkOutput("bus_flush", int'(bus_flush), int'(sb[0].flush));
        end
      end
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          checkOutput("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("done_onehot", int'(done), 1 << e.src);
          checkOutput("latency", cyc - grant_cyc, e.lat);
          checkOutput("bus_used", int'(bus_seen), int'(e.op != 0));
        end
      end
    end
  end

  task automatic readState(input int cache, input int addr, output int st);
    dbg_cache = cache[0];
    dbg_addr  = addr[1:0];
    #1;
    st = int'(dbg_state);
  endtask

  // Drive one request, wait for its acceptance and completion, then check
  // the resulting line state in both caches.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   st;
    bit   got;
    @(negedge clk);
    e.src   = v.cache;
    e.addr  = v.addr;
    e.op    = v.exp_op;
    e.flush = v.exp_flush;
    e.lat   = v.exp_lat;
    sb.push_back(e);
    req_write[v.cache]            = v.wr;
    req_addr[v.cache*2 +: 2]      = v.addr[1:0];
    req_valid[v.cache]            = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[v.cache]) begin
        got = 1'b1;
        break;
      end
    end
    req_valid[v.cache] = 1'b0;
    if (!got) begin
      checkOutput("grant_timeout", 0, 1);
      sb.delete();
      return;
    end
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 0, 1);
      sb.delete();
    end
    readState(v.cache, v.addr, st);
    checkOutput("req_line_state", st, v.exp_req_st);
    readState(1 - v.cache, v.addr, st);
    checkOutput("other_line_state", st, v.exp_oth_st);
  endtask

  initial begin
    int st;
    int gcount;
    int gidx[4];
    int gcyc[4];
    bit done_seen;
    bit got;

    checks    = 0;
    errors    = 0;
    mon_en    = 1'b0;
    bus_seen  = 1'b0;
    grant_cyc = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    dbg_cache = 1'b0;
    dbg_addr  = '0;

    //               cache wr addr op fl  req   other  lat
    vecs[0]  = '{0, 1'b0, 1, 1, 1'b0, ST_E, ST_I, 3};
    vecs[1]  = '{0, 1'b1, 1, 0, 1'b0, ST_M, ST_I, 2};
    vecs[2]  = '{1, 1'b0, 1, 1, 1'b1, ST_S, ST_S, 3};
    vecs[3]  = '{1, 1'b1, 1, 3, 1'b0, ST_M, ST_I, 3};
    vecs[4]  = '{0, 1'b1, 2, 2, 1'b0, ST_M, ST_I, 3};
    vecs[5]  = '{1, 1'b0, 2, 1, 1'b1, ST_S, ST_S, 3};
    vecs[6]  = '{0, 1'b0, 2, 0, 1'b0, ST_S, ST_S, 2};
    vecs[7]  = '{1, 1'b1, 2, 3, 1'b0, ST_M, ST_I, 3};
    vecs[8]  = '{0, 1'b1, 2, 2, 1'b1, ST_M, ST_I, 3};
    vecs[9]  = '{1, 1'b1, 3, 2, 1'b0, ST_M, ST_I, 3};
    vecs[10] = '{1, 1'b0, 3, 0, 1'b0, ST_M, ST_I, 2};
    vecs[11] = '{0, 1'b0, 0, 1, 1'b0, ST_E, ST_I, 3};
    vecs[12] = '{1, 1'b0, 0, 1, 1'b0, ST_S, ST_S, 3};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_req_ready", int'(req_ready), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_bus_valid", int'(bus_valid), 0);
    checkOutput("rst_bus_op", int'(bus_op), 0);
    checkOutput("rst_bus_flush", int'(bus_flush), 0);
    readState(0, 1, st);
    checkOutput("rst_dbg_c0l1", st, ST_I);
    readState(1, 3, st);
    checkOutput("rst_dbg_c1l3", st, ST_I);

    $display("[TB] request table");
    mon_en = 1'b1;
    foreach (vecs[i]) applyStimulus(vecs[i]);
    mon_en = 1'b0;

    // Both caches request continuously; line 0 is shared so every grant is
    // a hit and grants must alternate three cycles apart.
    $display("[TB] round-robin arbitration");
    @(negedge clk);
    req_write = 2'b00;
    req_addr  = 4'b0000;
    req_valid = 2'b11;
    gcount    = 0;
    for (int k = 0; k < 40 && gcount < 4; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        checkOutput("arb_onehot", int'($onehot(req_ready)), 1);
        gidx[gcount] = req_ready[1] ? 1 : 0;
        gcyc[gcount] = cyc;
        gcount++;
      end
    end
    req_valid = 2'b00;
    checkOutput("arb_grant_count", gcount, 4);
    for (int k = 0; k < gcount; k++) begin
      checkOutput("arb_order", gidx[k], k % 2);
      if (k > 0) checkOutput("arb_spacing", gcyc[k] - gcyc[k-1], 3);
    end
    repeat (5) @(negedge clk);

    // Cache 0 writes line 3 while cache 1 holds it M; reset lands in the
    // bus cycle of the BusRdX.
    $display("[TB] reset during bus cycle");
    req_write[0]  = 1'b1;
    req_addr[1:0] = 2'd3;
    req_valid[0]  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) req_valid[0] = 1'b0;
      if (bus_valid) begin
        got = 1'b1;
        break;
      end
    end
    req_valid[0] = 1'b0;
    checkOutput("rdx_bus_seen", int'(got), 1);
    checkOutput("rdx_bus_op", int'(bus_op), 2);
    checkOutput("rdx_bus_flush", int'(bus_flush), 1);
    rst_n     = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done != 2'b00) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done != 2'b00) done_seen = 1'b1;
    end
    checkOutput("abandoned_done", int'(done_seen), 0);
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 4; a++) begin
        readState(c, a, st);
        checkOutput("post_rst_state", st, ST_I);
      end

    $display("[TB] statistics counters");
    checkOutput("stat_bus_after_rst", int'(stat_bus_cnt), 0);
    checkOutput("stat_flush_after_rst", int'(stat_flush_cnt), 0);
    mon_en = 1'b1;
    applyStimulus('{0, 1'b0, 1, 1, 1'b0, ST_E, ST_I, 3});
    mon_en = 1'b0;
`ifdef SNOOP_STATS_EN
    checkOutput("stat_bus_one_miss", int'(stat_bus_cnt), 1);
    checkOutput("stat_flush_one_miss", int'(stat_flush_cnt), 0);
`else
    checkOutput("stat_bus_tied", int'(stat_bus_cnt), 0);
    checkOutput("stat_flush_tied", int'(stat_flush_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
